// File: rtl/uart_rx_oversamp_if.sv
`timescale 1ns/1ps
// Bundle of configuration, serial line and received-frame signals for one
// UART receive channel. The receiver connects through the slave modport;
// the pad/config side and the byte-level consumer use the master modport.
interface uart_rx_oversamp_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
);
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 start_flag;
    logic                 busy;

    modport master (
        output baud_div, parity_mode, rx_in,
        input  rx_data, rx_valid, parity_err, frame_err, start_flag, busy
    );

    modport slave (
        input  baud_div, parity_mode, rx_in,
        output rx_data, rx_valid, parity_err, frame_err, start_flag, busy
    );
endinterface

// File: rtl/uart_rx_oversamp.sv
`timescale 1ns/1ps
// Oversampling UART frame receiver: synchronises the async rx line, divides
// clk into oversample ticks, majority-votes VOTE centred samples per bit and
// assembles start/data/parity/stop into a word plus error flags.
module uart_rx_oversamp #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int VOTE      = 3,
    parameter int DIV_W     = 16
) (
    input logic clk,
    input logic rst,
    uart_rx_oversamp_if.slave rx_if
);

    localparam int TICK_W = $clog2(OVS);
    localparam int ONES_W = $clog2(VOTE + 1);
    localparam int BITC_W = $clog2(DATA_BITS + 1);
    localparam int VLO    = OVS / 2 - VOTE / 2;   // first vote tick
    localparam int VHI    = OVS / 2 + VOTE / 2;   // last vote tick

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    // Synchroniser and edge-detect flops
    logic sync1_q, rxs_q, rxs_prev_q;

    // Per-frame latched configuration
    logic [DIV_W-1:0] baud_div_q, baud_div_d;
    logic [1:0]       mode_q, mode_d;

    // Timing and voting counters
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [BITC_W-1:0] bit_cnt_q, bit_cnt_d;

    // Frame assembly
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;

    // Output registers
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 start_flag_q, start_flag_d;
    logic                 busy;

    // Decoded timing events
    logic [DIV_W-1:0]  div_eff;
    logic [ONES_W-1:0] ones_sum;
    logic              start_det;
    logic              tick;
    logic              in_vote;
    logic              vote_last;
    logic              bit_end;
    logic              voted;
    logic              par_en;
    logic              exp_par;

    assign div_eff   = (baud_div_q == '0) ? DIV_W'(1) : baud_div_q;
    assign start_det = (state_q == S_IDLE) && rxs_prev_q && !rxs_q;
    assign tick      = (state_q != S_IDLE) && (div_cnt_q == div_eff - DIV_W'(1));
    assign in_vote   = tick && (tick_cnt_q >= TICK_W'(VLO)) && (tick_cnt_q <= TICK_W'(VHI));
    assign vote_last = tick && (tick_cnt_q == TICK_W'(VHI));
    assign bit_end   = tick && (tick_cnt_q == TICK_W'(OVS - 1));
    // The vote includes the sample being taken this tick, so the bit value is
    // available on the last vote tick itself.
    assign ones_sum  = ones_cnt_q + ONES_W'(rxs_q);
    assign voted     = (ones_sum > ONES_W'(VOTE / 2));
    assign par_en    = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign exp_par   = (^shift_q) ^ (mode_q == 2'd2);

    // Two-flop synchroniser plus one flop of history for falling-edge detect
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge value of its neighbours.
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_if.rx_in;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; bit decisions happen on the last vote tick,
    // bit-to-bit advances on the final tick of the bit
    always_comb begin
        // NOTE: defaulting every combinational output first prevents latches
        // on paths that do not assign it.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_det) state_d = S_START;
            end
            S_START: begin
                if (vote_last && voted) state_d = S_IDLE;
                else if (bit_end)       state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_cnt_q == BITC_W'(DATA_BITS)))
                    state_d = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output logic
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath next-state: tick divider, bit timing, voting, shifting, outputs
    always_comb begin
        baud_div_d   = baud_div_q;
        mode_d       = mode_q;
        div_cnt_d    = div_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;
        start_flag_d = start_det;

        if (start_det) begin
            // Configuration is frozen for the whole frame from here on
            baud_div_d = rx_if.baud_div;
            mode_d     = rx_if.parity_mode;
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            ones_cnt_d = '0;
            bit_cnt_d  = '0;
            perr_d     = 1'b0;
        end else if (state_q != S_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                tick_cnt_d = (tick_cnt_q == TICK_W'(OVS - 1)) ? '0 : tick_cnt_q + TICK_W'(1);
                if (in_vote) ones_cnt_d = ones_sum;
                if (bit_end) ones_cnt_d = '0;
            end
            if (vote_last) begin
                unique case (state_q)
                    S_DATA: begin
                        shift_d   = {voted, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BITC_W'(1);
                    end
                    S_PARITY: begin
                        perr_d = voted ^ exp_par;
                    end
                    S_STOP: begin
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = par_en ? perr_q : 1'b0;
                        frame_err_d  = !voted;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div_q   <= '0;
            mode_q       <= '0;
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            start_flag_q <= 1'b0;
        end else begin
            baud_div_q   <= baud_div_d;
            mode_q       <= mode_d;
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            start_flag_q <= start_flag_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.start_flag = start_flag_q;
    assign rx_if.busy       = busy;

endmodule
